mem_burst_arbiter: RTL and testbench
====================================

Name: mem_burst_arbiter

Overview:
- Shares one burst-level DDR port (rd/wr burst req, len, addr, data, finish) between two client channels, ch0 and ch1.
- Each channel has an independent read and an independent write burst interface.
- The block sits between the clients (e.g. frame writer, frame reader) and the burst controller.
- It grants one burst at a time using four-slot round-robin, muxes the request fields downstream, and routes handshakes and data back to the granted client only.

Parameters:
MEM_DATA_BITS, 256, burst data width
ADDR_BITS, 28, controller address width; burst addresses are ADDR_BITS-3 bits

Ports:
mem_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
init_calib_complete  in  1  memory ready; no grants while low
chN_wr_req  in  1  (N=0,1) write burst request, level, held until chN_wr_finish
chN_wr_len  in  10  write burst length in beats
chN_wr_addr  in  ADDR_BITS-3  write start address
chN_wr_data  in  MEM_DATA_BITS  write data
chN_wr_data_req  out  1  pop next write beat (granted client only)
chN_wr_finish  out  1  one-cycle write completion pulse
chN_rd_req  in  1  read burst request, level, held until chN_rd_finish
chN_rd_len  in  10  read burst length
chN_rd_addr  in  ADDR_BITS-3  read start address
chN_rd_data  out  MEM_DATA_BITS  read data (broadcast)
chN_rd_data_valid  out  1  read beat valid (granted client only)
chN_rd_finish  out  1  one-cycle read completion pulse
rd_burst_req, wr_burst_req  out  1  downstream requests
rd_burst_len, wr_burst_len  out  10  downstream lengths
rd_burst_addr, wr_burst_addr  out  ADDR_BITS-3  downstream addresses
wr_burst_data  out  MEM_DATA_BITS  downstream write data
wr_burst_data_req, rd_burst_data_valid, rd_burst_finish, wr_burst_finish  in  1  downstream handshakes
rd_burst_data  in  MEM_DATA_BITS  downstream read data
grant  out  2  current slot index
busy  out  1  a burst is granted

Behaviour:
- Slot numbering: 0=ch0_wr, 1=ch0_rd, 2=ch1_wr, 3=ch1_rd.
- Round-robin pointer ptr (2 bits): the search starts at ptr and proceeds ptr, ptr+1, … mod 4.
- Reset (rst_n low, asynchronous):
  - state IDLE, ptr=0, grant=0, busy=0.
  - All downstream reqs 0; all client finish, data_req and data_valid outputs 0.
  - Reset mid-burst abandons the burst with no finish to the client.
- States:
  - IDLE: stay here while init_calib_complete=0. Otherwise pick the first requesting slot from ptr, register grant and busy=1, then go to ZCHK. No request: stay.
  - ZCHK: if the granted len==0, go to FIN without touching downstream. Else assert the registered rd_burst_req or wr_burst_req (by slot type) and go to RUN.
  - RUN: hold the downstream req. On the downstream finish of the matching type, drop the req at that edge and go to FIN.
  - FIN (1 cycle): pulse the granted client's finish, set ptr=grant+1, busy=0, and go to GAP.
  - GAP (1 cycle): all requests ignored, so the finished client can deassert its req. Then go to IDLE.
- Latency: client req high at edge k gives downstream req high from edge k+2. Client finish is 2 cycles after downstream finish.
- Muxing:
  - Downstream len, addr and wr_burst_data are combinational muxes selected by the registered grant.
  - Unselected-type downstream fields are driven 0.
  - Clients hold len and addr stable while their req is high.
- Routing:
  - wr_burst_data_req goes to the granted write client only.
  - rd_burst_data_valid goes to the granted read client only.
  - rd_burst_data is broadcast to both channels.
  - Every non-granted handshake output is 0.
- A downstream finish of the wrong type, or one arriving outside RUN, is ignored.
- init_calib_complete falling during RUN: the burst is allowed to complete. No new grant is made until it is high again.
- A client deasserting its req while granted does not cancel the burst.

Test Plan:
- Single request: ch0_wr_req with len=4, addr=0x100 → wr_burst_req rises 2 cycles later with wr_burst_addr=0x100 and len=4. After 4 data_req beats and downstream finish, ch0_wr_finish pulses once and grant=0.
- Contention: all four reqs held from reset → grant sequence 0,1,2,3,0. Each burst gets exactly one finish. At least one cycle with busy=0 separates bursts.
- Fairness: ch0_rd stays requesting continuously while ch1_wr requests once → ch1_wr is granted no later than the second arbitration.
- Zero length: ch1_rd_len=0 → no downstream req, and ch1_rd_finish pulses 2 cycles after grant.
- Routing: during a ch1_rd burst, rd_burst_data_valid pulses → only ch1_rd_data_valid toggles, and ch0_rd_data_valid stays 0. A spurious wr_burst_finish is ignored.
- Reset and calibration: rst_n low mid-RUN → all outputs 0 immediately and ptr=0. init_calib_complete=0 with requests pending → no grant until it rises.

Source files
------------

// File: rtl/mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_arbiter
// Description : Four-slot round-robin arbiter sharing one burst-level DDR
//               port between two channels, each with a read and a write
//               burst interface. One burst is granted at a time; request
//               fields are muxed downstream and handshakes are routed back
//               to the granted client only.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_arbiter #(
  parameter int MEM_DATA_BITS = 256,
  parameter int ADDR_BITS     = 28
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     init_calib_complete,
  // channel 0 write
  input  logic                     ch0_wr_req,
  input  logic [9:0]               ch0_wr_len,
  input  logic [ADDR_BITS-4:0]     ch0_wr_addr,
  input  logic [MEM_DATA_BITS-1:0] ch0_wr_data,
  output logic                     ch0_wr_data_req,
  output logic                     ch0_wr_finish,
  // channel 0 read
  input  logic                     ch0_rd_req,
  input  logic [9:0]               ch0_rd_len,
  input  logic [ADDR_BITS-4:0]     ch0_rd_addr,
  output logic [MEM_DATA_BITS-1:0] ch0_rd_data,
  output logic                     ch0_rd_data_valid,
  output logic                     ch0_rd_finish,
  // channel 1 write
  input  logic                     ch1_wr_req,
  input  logic [9:0]               ch1_wr_len,
  input  logic [ADDR_BITS-4:0]     ch1_wr_addr,
  input  logic [MEM_DATA_BITS-1:0] ch1_wr_data,
  output logic                     ch1_wr_data_req,
  output logic                     ch1_wr_finish,
  // channel 1 read
  input  logic                     ch1_rd_req,
  input  logic [9:0]               ch1_rd_len,
  input  logic [ADDR_BITS-4:0]     ch1_rd_addr,
  output logic [MEM_DATA_BITS-1:0] ch1_rd_data,
  output logic                     ch1_rd_data_valid,
  output logic                     ch1_rd_finish,
  // downstream burst controller
  output logic                     rd_burst_req,
  output logic                     wr_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-4:0]     rd_burst_addr,
  output logic [ADDR_BITS-4:0]     wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_data_req,
  input  logic                     rd_burst_data_valid,
  input  logic                     rd_burst_finish,
  input  logic                     wr_burst_finish,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  // status
  output logic [1:0]               grant,
  output logic                     busy
);

  // Slot encoding: bit 0 = read (1) / write (0), bit 1 = channel.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ZCHK = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIN  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t state;
  logic [1:0] ptr;
  logic [3:0] fin_pulse;

  logic [3:0] req_vec;
  logic       pick_valid;
  logic [1:0] pick_slot;

  logic [9:0]               gr_wr_len;
  logic [9:0]               gr_rd_len;
  logic [ADDR_BITS-4:0]     gr_wr_addr;
  logic [ADDR_BITS-4:0]     gr_rd_addr;
  logic [MEM_DATA_BITS-1:0] gr_wr_data;
  logic [9:0]               granted_len;

  assign req_vec = {ch1_rd_req, ch1_wr_req, ch0_rd_req, ch0_wr_req};

  // Round-robin search: scan offsets high to low so the nearest slot to ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_slot  = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req_vec[ptr + 2'(i)]) begin
        pick_valid = 1'b1;
        pick_slot  = ptr + 2'(i);
      end
    end
  end

  // Field selection by the registered grant; the other burst type sees zeros.
  always_comb begin
    gr_wr_len     = grant[1] ? ch1_wr_len  : ch0_wr_len;
    gr_rd_len     = grant[1] ? ch1_rd_len  : ch0_rd_len;
    gr_wr_addr    = grant[1] ? ch1_wr_addr : ch0_wr_addr;
    gr_rd_addr    = grant[1] ? ch1_rd_addr : ch0_rd_addr;
    gr_wr_data    = grant[1] ? ch1_wr_data : ch0_wr_data;
    granted_len   = grant[0] ? gr_rd_len   : gr_wr_len;
    wr_burst_len  = grant[0] ? 10'd0 : gr_wr_len;
    wr_burst_addr = grant[0] ? '0    : gr_wr_addr;
    wr_burst_data = grant[0] ? '0    : gr_wr_data;
    rd_burst_len  = grant[0] ? gr_rd_len  : 10'd0;
    rd_burst_addr = grant[0] ? gr_rd_addr : '0;
  end

  // Handshake routing back to the granted client only; read data is broadcast.
  always_comb begin
    ch0_wr_data_req   = busy && (grant == 2'd0) && wr_burst_data_req;
    ch1_wr_data_req   = busy && (grant == 2'd2) && wr_burst_data_req;
    ch0_rd_data_valid = busy && (grant == 2'd1) && rd_burst_data_valid;
    ch1_rd_data_valid = busy && (grant == 2'd3) && rd_burst_data_valid;
    ch0_rd_data       = rd_burst_data;
    ch1_rd_data       = rd_burst_data;
  end

  assign ch0_wr_finish = fin_pulse[0];
  assign ch0_rd_finish = fin_pulse[1];
  assign ch1_wr_finish = fin_pulse[2];
  assign ch1_rd_finish = fin_pulse[3];

  // Arbitration FSM with registered grant, busy, downstream reqs and finish pulses.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= 2'd0;
      grant        <= 2'd0;
      busy         <= 1'b0;
      rd_burst_req <= 1'b0;
      wr_burst_req <= 1'b0;
      fin_pulse    <= 4'd0;
    end else begin
      fin_pulse <= 4'd0;
      case (state)
        ST_IDLE: begin
          if (init_calib_complete && pick_valid) begin
            grant <= pick_slot;
            busy  <= 1'b1;
            state <= ST_ZCHK;
          end
        end
        ST_ZCHK: begin
          if (granted_len == 10'd0) begin
            state <= ST_FIN;
          end else begin
            if (grant[0]) rd_burst_req <= 1'b1;
            else          wr_burst_req <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Only the finish matching the granted burst type ends the burst.
          if (grant[0] && rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            state        <= ST_FIN;
          end else if (!grant[0] && wr_burst_finish) begin
            wr_burst_req <= 1'b0;
            state        <= ST_FIN;
          end
        end
        ST_FIN: begin
          fin_pulse <= 4'b0001 << grant;
          ptr       <= grant + 2'd1;
          busy      <= 1'b0;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          // One dead cycle lets the finished client drop its request.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_arbiter
// Description : Directed bench for mem_burst_arbiter with a behavioural burst
//               controller and a grant-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_arbiter;

  localparam int DW = 256;
  localparam int AW = 25;

  logic mem_clk;
  logic rst_n;
  logic init_calib_complete;

  int rem [4];
  logic [9:0]    cfg_len  [4];
  logic [AW-1:0] cfg_addr [4];
  logic [DW-1:0] wdata0, wdata1;

  logic ch0_wr_req, ch0_rd_req, ch1_wr_req, ch1_rd_req;
  logic ch0_wr_data_req, ch0_wr_finish, ch0_rd_data_valid, ch0_rd_finish;
  logic ch1_wr_data_req, ch1_wr_finish, ch1_rd_data_valid, ch1_rd_finish;
  logic [DW-1:0] ch0_rd_data, ch1_rd_data;
  logic rd_burst_req, wr_burst_req;
  logic [9:0] rd_burst_len, wr_burst_len;
  logic [AW-1:0] rd_burst_addr, wr_burst_addr;
  logic [DW-1:0] wr_burst_data, rd_burst_data;
  logic wr_burst_data_req, rd_burst_data_valid;
  logic m_wr_fin, m_rd_fin, spur_wr_fin;
  logic wr_burst_finish, rd_burst_finish;
  logic [1:0] grant;
  logic busy;

  assign ch0_wr_req      = (rem[0] != 0);
  assign ch0_rd_req      = (rem[1] != 0);
  assign ch1_wr_req      = (rem[2] != 0);
  assign ch1_rd_req      = (rem[3] != 0);
  assign wr_burst_finish = m_wr_fin | spur_wr_fin;
  assign rd_burst_finish = m_rd_fin;

  mem_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(28)) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .ch0_wr_req(ch0_wr_req), .ch0_wr_len(cfg_len[0]), .ch0_wr_addr(cfg_addr[0]),
    .ch0_wr_data(wdata0), .ch0_wr_data_req(ch0_wr_data_req), .ch0_wr_finish(ch0_wr_finish),
    .ch0_rd_req(ch0_rd_req), .ch0_rd_len(cfg_len[1]), .ch0_rd_addr(cfg_addr[1]),
    .ch0_rd_data(ch0_rd_data), .ch0_rd_data_valid(ch0_rd_data_valid), .ch0_rd_finish(ch0_rd_finish),
    .ch1_wr_req(ch1_wr_req), .ch1_wr_len(cfg_len[2]), .ch1_wr_addr(cfg_addr[2]),
    .ch1_wr_data(wdata1), .ch1_wr_data_req(ch1_wr_data_req), .ch1_wr_finish(ch1_wr_finish),
    .ch1_rd_req(ch1_rd_req), .ch1_rd_len(cfg_len[3]), .ch1_rd_addr(cfg_addr[3]),
    .ch1_rd_data(ch1_rd_data), .ch1_rd_data_valid(ch1_rd_data_valid), .ch1_rd_finish(ch1_rd_finish),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
    .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
    .wr_burst_finish(wr_burst_finish), .rd_burst_data(rd_burst_data),
    .grant(grant), .busy(busy)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Behavioural write controller: len data_req beats, then a one-cycle finish.
  logic [1:0] wst, rst_st;
  logic [9:0] wcnt, rcnt;
  always @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wst <= 2'd0; wcnt <= 10'd0; m_wr_fin <= 1'b0; wr_burst_data_req <= 1'b0;
    end else begin
      m_wr_fin <= 1'b0; wr_burst_data_req <= 1'b0;
      case (wst)
        2'd0: if (wr_burst_req) begin wcnt <= 10'd0; wst <= 2'd1; end
        2'd1: if (wcnt == wr_burst_len) begin m_wr_fin <= 1'b1; wst <= 2'd2; end
              else begin wr_burst_data_req <= 1'b1; wcnt <= wcnt + 10'd1; end
        default: wst <= 2'd0;
      endcase
    end
  end

  // Behavioural read controller: len valid beats with a counting data pattern.
  always @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_st <= 2'd0; rcnt <= 10'd0; m_rd_fin <= 1'b0; rd_burst_data_valid <= 1'b0;
      rd_burst_data <= '0;
    end else begin
      m_rd_fin <= 1'b0; rd_burst_data_valid <= 1'b0;
      case (rst_st)
        2'd0: if (rd_burst_req) begin rcnt <= 10'd0; rst_st <= 2'd1; end
        2'd1: if (rcnt == rd_burst_len) begin m_rd_fin <= 1'b1; rst_st <= 2'd2; end
              else begin
                rd_burst_data_valid <= 1'b1;
                rd_burst_data <= {8{22'h2A5A5A, rcnt}};
                rcnt <= rcnt + 10'd1;
              end
        default: rst_st <= 2'd0;
      endcase
    end
  end

  int tests = 0;
  int fails = 0;
  int exp_q [$];
  int cur_slot = 0;
  int cyc = 0;
  int fin_cnt [4];
  int fin_cyc [4];
  int grant_cyc = 0;
  int dfin_cyc = 0;
  int busy_rises = 0;
  int ds_rises = 0;
  int dv0_cnt = 0, dv1_cnt = 0, dr0_cnt = 0;
  logic prev_busy = 1'b0, prev_wreq = 1'b0, prev_rreq = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge and run the scoreboard/monitor checks.
  task automatic tick();
    logic [3:0] fv;
    logic [1:0] wexp, rexp;
    @(negedge mem_clk);
    cyc++;
    if (busy && !prev_busy) begin
      busy_rises++;
      grant_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 256'(grant), 256'(4));
      end else begin
        cur_slot = exp_q.pop_front();
        check("grant_order", 256'(grant), 256'(cur_slot));
      end
    end
    if (wr_burst_req && !prev_wreq) begin
      ds_rises++;
      check("wr_addr", 256'(wr_burst_addr), 256'(cfg_addr[cur_slot]));
      check("wr_len", 256'(wr_burst_len), 256'(cfg_len[cur_slot]));
      check("wr_data", wr_burst_data, (cur_slot == 2) ? wdata1 : wdata0);
    end
    if (rd_burst_req && !prev_rreq) begin
      ds_rises++;
      check("rd_addr", 256'(rd_burst_addr), 256'(cfg_addr[cur_slot]));
      check("rd_len", 256'(rd_burst_len), 256'(cfg_len[cur_slot]));
    end
    if (m_wr_fin || m_rd_fin) dfin_cyc = cyc;
    fv = {ch1_rd_finish, ch1_wr_finish, ch0_rd_finish, ch0_wr_finish};
    if (fv != 4'd0) begin
      check("finish_slot", 256'(fv), 256'(4'b0001 << cur_slot));
      fin_cnt[cur_slot]++;
      fin_cyc[cur_slot] = cyc;
      if (rem[cur_slot] > 0) rem[cur_slot]--;
    end
    wexp = (cur_slot == 0) ? 2'b01 : (cur_slot == 2) ? 2'b10 : 2'b00;
    rexp = (cur_slot == 1) ? 2'b01 : (cur_slot == 3) ? 2'b10 : 2'b00;
    if (wr_burst_data_req)
      check("wr_route", 256'({ch1_wr_data_req, ch0_wr_data_req}), 256'(wexp));
    if (rd_burst_data_valid) begin
      check("rd_route", 256'({ch1_rd_data_valid, ch0_rd_data_valid}), 256'(rexp));
      check("rd_bcast", {ch0_rd_data ^ ch1_rd_data}, 256'(0));
    end
    dv0_cnt += int'(ch0_rd_data_valid);
    dv1_cnt += int'(ch1_rd_data_valid);
    dr0_cnt += int'(ch0_wr_data_req);
    prev_busy = busy; prev_wreq = wr_burst_req; prev_rreq = rd_burst_req;
  endtask

  task automatic run_quiet(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      done = (exp_q.size() == 0) && (rem[0] == 0) && (rem[1] == 0) &&
             (rem[2] == 0) && (rem[3] == 0) && !busy;
      if (done) break;
      tick();
    end
    if (!done) check("timeout_quiet", 256'(0), 256'(1));
    tick(); tick();
  endtask

  task automatic wait_sig(input string tag, input int which, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      seen = (which == 0) ? wr_burst_req : rd_burst_req;
      if (seen) break;
      tick();
    end
    if (!seen) check(tag, 256'(0), 256'(1));
  endtask

  initial begin
    int snap, f0, f1, dv0, dv1, d0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; fin_cnt[i] = 0; fin_cyc[i] = 0;
      cfg_len[i] = 10'd2; cfg_addr[i] = AW'(32'h1000 * (i + 1));
    end
    wdata0 = {8{32'hC0DE_0000}};
    wdata1 = {8{32'hFACE_1111}};
    spur_wr_fin = 1'b0;
    init_calib_complete = 1'b1;
    rst_n = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_grant", 256'(grant), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_reqs", 256'({wr_burst_req, rd_burst_req}), 256'(0));
    check("rst_fin", 256'({ch1_rd_finish, ch1_wr_finish, ch0_rd_finish, ch0_wr_finish}), 256'(0));
    rst_n = 1'b1;
    tick();

    // Single write request: two-cycle latency, 4 beats, finish 2 cycles after downstream
    cfg_len[0] = 10'd4; cfg_addr[0] = AW'(32'h100);
    d0 = dr0_cnt;
    exp_q.push_back(0);
    rem[0] = 1;
    tick();
    check("single_busy", 256'(busy), 256'(1));
    check("single_req_early", 256'(wr_burst_req), 256'(0));
    tick();
    check("single_req_on", 256'(wr_burst_req), 256'(1));
    run_quiet(100);
    check("single_fin_cnt", 256'(fin_cnt[0]), 256'(1));
    check("single_beats", 256'(dr0_cnt - d0), 256'(4));
    check("single_fin_lat", 256'(fin_cyc[0] - dfin_cyc), 256'(2));
    check("single_grant", 256'(grant), 256'(0));

    // Contention: all four held from reset -> 0,1,2,3,0
    rst_n = 1'b0;
    cfg_len[0] = 10'd3; cfg_len[1] = 10'd2; cfg_len[2] = 10'd5; cfg_len[3] = 10'd1;
    for (int i = 0; i < 4; i++) fin_cnt[i] = 0;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    exp_q = '{0, 1, 2, 3, 0};
    tick();
    snap = busy_rises;
    rst_n = 1'b1;
    run_quiet(300);
    check("cont_fin", 256'({fin_cnt[3][7:0], fin_cnt[2][7:0], fin_cnt[1][7:0], fin_cnt[0][7:0]}),
          256'(32'h01010102));
    check("cont_bursts", 256'(busy_rises - snap), 256'(5));

    // Fairness: ch0_rd streams, ch1_wr asks once -> 1,2,1,1
    exp_q = '{1, 2, 1, 1};
    rem[1] = 3; rem[2] = 1;
    run_quiet(300);
    check("fair_ch1wr_fin", 256'(fin_cnt[2]), 256'(2));

    // Zero length read on ch1: no downstream req, finish 2 cycles after grant
    cfg_len[3] = 10'd0;
    snap = ds_rises;
    exp_q.push_back(3);
    rem[3] = 1;
    run_quiet(50);
    check("zero_no_ds", 256'(ds_rises - snap), 256'(0));
    check("zero_fin_lat", 256'(fin_cyc[3] - grant_cyc), 256'(2));

    // Routing during a ch1 read, with a spurious write finish mid-burst
    cfg_len[3] = 10'd3;
    dv0 = dv0_cnt; dv1 = dv1_cnt; f1 = fin_cnt[2];
    exp_q.push_back(3);
    rem[3] = 1;
    wait_sig("route_wait_rd", 1, 20);
    spur_wr_fin = 1'b1;
    tick();
    spur_wr_fin = 1'b0;
    tick();
    check("spur_keep_req", 256'({busy, rd_burst_req}), 256'(2'b11));
    run_quiet(50);
    check("route_ch1_dv", 256'(dv1_cnt - dv1), 256'(3));
    check("route_ch0_dv", 256'(dv0_cnt - dv0), 256'(0));
    check("route_wrfin", 256'(fin_cnt[2] - f1), 256'(0));
    spur_wr_fin = 1'b1;
    tick();
    spur_wr_fin = 1'b0;
    tick();
    check("spur_idle", 256'(busy), 256'(0));

    // Reset mid-RUN: move ptr to 2, start ch1_wr, abandon it, then check ptr=0
    exp_q.push_back(1);
    rem[1] = 1;
    run_quiet(50);
    cfg_len[2] = 10'd8;
    f1 = fin_cnt[2];
    exp_q.push_back(2);
    rem[2] = 1;
    wait_sig("rst_wait_wr", 0, 20);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", 256'({busy, grant, wr_burst_req, rd_burst_req, ch1_wr_data_req,
                                 ch1_wr_finish, ch0_wr_finish}), 256'(0));
    rem[2] = 0; rem[1] = 1; rem[3] = 1;
    exp_q = '{1, 3};
    tick();
    rst_n = 1'b1;
    run_quiet(100);
    check("rst_abandon", 256'(fin_cnt[2] - f1), 256'(0));

    // Calibration gating, and calibration dropping mid-burst
    init_calib_complete = 1'b0;
    rem[0] = 1;
    for (int i = 0; i < 5; i++) tick();
    check("calib_hold", 256'(busy), 256'(0));
    exp_q.push_back(0);
    f0 = fin_cnt[0];
    init_calib_complete = 1'b1;
    wait_sig("calib_wait_wr", 0, 20);
    init_calib_complete = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (fin_cnt[0] != f0) break;
      tick();
    end
    check("calib_drop_done", 256'(fin_cnt[0] - f0), 256'(1));
    rem[1] = 1;
    for (int i = 0; i < 6; i++) tick();
    check("calib_hold2", 256'(busy), 256'(0));
    exp_q.push_back(1);
    init_calib_complete = 1'b1;
    run_quiet(100);
    check("calib_resume", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
